// File: rtl/rd_scoreboard_if.sv
// Scoreboard interface: issue and write-back events, the operand addresses
// of the instruction in ID, and the scoreboard's status outputs.
interface rd_scoreboard_if #(
    parameter int UNIT_CNT = 6
);
    logic                issue_valid;
    logic [4:0]          issue_rd;
    logic                issue_rd_fp;
    logic [UNIT_CNT-1:0] issue_unit;
    logic                wb_valid;
    logic [4:0]          wb_rd;
    logic                wb_rd_fp;
    logic [UNIT_CNT-1:0] wb_unit;
    logic [4:0]          id_rs1, id_rs2, id_rs3, id_rd;
    logic                id_rs1_fp, id_rs2_fp, id_rs3_fp, id_rd_fp;
    logic                id_use_rs1, id_use_rs2, id_use_rs3, id_use_rd;
    logic                rd_busy;
    logic [UNIT_CNT-1:0] unit_full;
    logic                unit_idle;
    logic                scbd_err;

    // Pipeline side: produces events and ID operands, consumes status.
    modport master (
        output issue_valid, issue_rd, issue_rd_fp, issue_unit,
        output wb_valid, wb_rd, wb_rd_fp, wb_unit,
        output id_rs1, id_rs2, id_rs3, id_rd,
        output id_rs1_fp, id_rs2_fp, id_rs3_fp, id_rd_fp,
        output id_use_rs1, id_use_rs2, id_use_rs3, id_use_rd,
        input  rd_busy, unit_full, unit_idle, scbd_err
    );

    // Scoreboard side.
    modport slave (
        input  issue_valid, issue_rd, issue_rd_fp, issue_unit,
        input  wb_valid, wb_rd, wb_rd_fp, wb_unit,
        input  id_rs1, id_rs2, id_rs3, id_rd,
        input  id_rs1_fp, id_rs2_fp, id_rs3_fp, id_rd_fp,
        input  id_use_rs1, id_use_rs2, id_use_rs3, id_use_rd,
        output rd_busy, unit_full, unit_idle, scbd_err
    );
endinterface

// File: rtl/rd_scoreboard.sv
// Destination-register scoreboard for long-latency units (FSQRT, DIV, FDIV,
// R4, FMUL, FADD). 64 busy bits indexed {fp, rd}, a unit tag per entry and a
// saturating in-flight counter per unit. Optional macro SCBD_WB_BYPASS_EN
// lets a same-cycle write-back release its own entry in the ID lookup.
module rd_scoreboard #(
    parameter int UNIT_CNT = 6,
    parameter int CNT_W    = 3,
    parameter int UNIT_MAX = 4
) (
    input  logic           clk,
    input  logic           reset,
    rd_scoreboard_if.slave bus
);
    logic [63:0]         busy_reg, busy_next, busy_view;
    logic [2:0]          tag_reg [64];
    logic                err_reg, err_next;
    logic [5:0]          issue_idx, wb_idx;
    logic [2:0]          issue_tag, wb_tag;
    logic                issue_onehot, issue_set;
    logic [UNIT_CNT-1:0] full_vec, empty_vec;
    logic [5:0]          op_idx [4];
    logic [3:0]          op_use, op_hit;

    // One-hot unit select to 3-bit tag.
    function automatic logic [2:0] encode(input logic [UNIT_CNT-1:0] oh);
        logic [2:0] e;
        e = '0;
        for (int i = 0; i < UNIT_CNT; i++)
            if (oh[i]) e = e | 3'(i);
        return e;
    endfunction

    assign issue_idx    = {bus.issue_rd_fp, bus.issue_rd};
    assign wb_idx       = {bus.wb_rd_fp, bus.wb_rd};
    assign issue_tag    = encode(bus.issue_unit);
    assign wb_tag       = encode(bus.wb_unit);
    assign issue_onehot = $onehot(bus.issue_unit);
    // Integer x0 is hard-wired zero and never becomes busy.
    assign issue_set    = bus.issue_valid && (issue_idx != 6'd0);

    // Next busy vector: write-back clears, then issue sets (issue wins).
    always_comb begin
        busy_next = busy_reg;
        if (bus.wb_valid) busy_next[wb_idx] = 1'b0;
        if (issue_set)    busy_next[issue_idx] = 1'b1;
    end

    // Busy bit register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) busy_reg <= '0;
        else       busy_reg <= busy_next;
    end

    // Tag storage, written with the unit of each issue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) tag_reg[i] <= '0;
        end else if (issue_set) begin
            tag_reg[issue_idx] <= issue_tag;
        end
    end

    // Per-unit in-flight counters; saturate at UNIT_MAX and at zero.
    generate
        for (genvar gi = 0; gi < UNIT_CNT; gi++) begin : g_unit
            logic [CNT_W-1:0] cnt_reg;
            logic             inc, dec;
            assign inc = bus.issue_valid && issue_onehot && bus.issue_unit[gi];
            assign dec = bus.wb_valid && bus.wb_unit[gi];
            assign full_vec[gi]  = (cnt_reg == CNT_W'(UNIT_MAX));
            assign empty_vec[gi] = (cnt_reg == '0);

            // Count up on issue, down on write-back, hold when both occur.
            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    cnt_reg <= '0;
                else if (inc && !dec && !full_vec[gi])
                    cnt_reg <= cnt_reg + CNT_W'(1);
                else if (dec && !inc && !empty_vec[gi])
                    cnt_reg <= cnt_reg - CNT_W'(1);
            end
        end
    endgenerate

    // Sticky protocol-violation detection against the pre-update state.
    always_comb begin
        err_next = err_reg;
        if (bus.issue_valid && !issue_onehot)                   err_next = 1'b1;
        if (bus.issue_valid && |(bus.issue_unit & full_vec))    err_next = 1'b1;
        if (bus.wb_valid && |(bus.wb_unit & empty_vec))        err_next = 1'b1;
        if (bus.wb_valid && (!busy_reg[wb_idx] || tag_reg[wb_idx] != wb_tag))
            err_next = 1'b1;
    end

    // Error flag register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_reg <= 1'b0;
        else       err_reg <= err_next;
    end

`ifdef SCBD_WB_BYPASS_EN
    logic [63:0] wb_mask;
    // Hide the entry being written back unless it is re-issued this cycle.
    always_comb begin
        wb_mask = '0;
        if (bus.wb_valid && !(bus.issue_valid && issue_idx == wb_idx))
            wb_mask[wb_idx] = 1'b1;
    end
    assign busy_view = busy_reg & ~wb_mask;
`else
    assign busy_view = busy_reg;
`endif

    assign op_idx[0] = {bus.id_rs1_fp, bus.id_rs1};
    assign op_idx[1] = {bus.id_rs2_fp, bus.id_rs2};
    assign op_idx[2] = {bus.id_rs3_fp, bus.id_rs3};
    assign op_idx[3] = {bus.id_rd_fp,  bus.id_rd};
    assign op_use    = {bus.id_use_rd, bus.id_use_rs3, bus.id_use_rs2, bus.id_use_rs1};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_op
            assign op_hit[gi] = op_use[gi] && (op_idx[gi] != 6'd0) && busy_view[op_idx[gi]];
        end
    endgenerate

    assign bus.rd_busy   = |op_hit;
    assign bus.unit_full = full_vec;
    assign bus.unit_idle = (busy_reg == '0) && (&empty_vec);
    assign bus.scbd_err  = err_reg;
endmodule

// File: tb/tb_rd_scoreboard.sv
// Self-checking bench for rd_scoreboard: directed scenarios followed by
// randomized issue/write-back traffic, compared against a reference model.
module tb_rd_scoreboard;
    localparam int UC   = 6;
    localparam int UMAX = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;

    rd_scoreboard_if #(.UNIT_CNT(UC)) bus();
    rd_scoreboard #(.UNIT_CNT(UC), .CNT_W(3), .UNIT_MAX(UMAX)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state.
    bit mbusy [64];
    int mtag  [64];
    int mcnt  [UC];
    bit merr;
    typedef struct { int idx; int unit; } flight_t;
    flight_t inflight[$];

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int oh_index(logic [UC-1:0] oh);
        if ($countones(oh) != 1) return -1;
        for (int i = 0; i < UC; i++) if (oh[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin mbusy[i] = 0; mtag[i] = 0; end
        for (int u = 0; u < UC; u++) mcnt[u] = 0;
        merr = 0;
        inflight.delete();
    endtask

    function automatic bit op_busy(bit use_, bit fp, logic [4:0] a);
        int idx;
        idx = {fp, a};
        if (!use_ || idx == 0) return 0;
`ifdef SCBD_WB_BYPASS_EN
        if (bus.wb_valid && {bus.wb_rd_fp, bus.wb_rd} == idx &&
            !(bus.issue_valid && {bus.issue_rd_fp, bus.issue_rd} == idx)) return 0;
`endif
        return mbusy[idx];
    endfunction

    task automatic idle_valids();
        bus.issue_valid = 0; bus.issue_rd = 0; bus.issue_rd_fp = 0; bus.issue_unit = 0;
        bus.wb_valid = 0; bus.wb_rd = 0; bus.wb_rd_fp = 0; bus.wb_unit = 0;
    endtask

    task automatic issue(int r, bit fp, logic [UC-1:0] u);
        bus.issue_valid = 1; bus.issue_rd = 5'(r); bus.issue_rd_fp = fp; bus.issue_unit = u;
    endtask

    task automatic wb(int r, bit fp, logic [UC-1:0] u);
        bus.wb_valid = 1; bus.wb_rd = 5'(r); bus.wb_rd_fp = fp; bus.wb_unit = u;
    endtask

    // Let inputs settle, then compare every output with the model.
    task automatic settle(string tag);
        bit exp_busy, exp_idle;
        logic [UC-1:0] exp_full;
        #1;
        exp_busy = op_busy(bus.id_use_rs1, bus.id_rs1_fp, bus.id_rs1) |
                   op_busy(bus.id_use_rs2, bus.id_rs2_fp, bus.id_rs2) |
                   op_busy(bus.id_use_rs3, bus.id_rs3_fp, bus.id_rs3) |
                   op_busy(bus.id_use_rd,  bus.id_rd_fp,  bus.id_rd);
        exp_idle = 1;
        for (int i = 0; i < 64; i++) if (mbusy[i]) exp_idle = 0;
        for (int u = 0; u < UC; u++) begin
            exp_full[u] = (mcnt[u] == UMAX);
            if (mcnt[u] != 0) exp_idle = 0;
        end
        check({tag, ".rd_busy"},   bus.rd_busy,   exp_busy);
        check({tag, ".unit_full"}, bus.unit_full, exp_full);
        check({tag, ".unit_idle"}, bus.unit_idle, exp_idle);
        check({tag, ".scbd_err"},  bus.scbd_err,  merr);
    endtask

    // Clock edge: apply the cycle's events to the model, then drop valids.
    task automatic advance();
        int iidx, widx, iu, wu, d;
        @(posedge clk);
        iidx = {bus.issue_rd_fp, bus.issue_rd};
        widx = {bus.wb_rd_fp, bus.wb_rd};
        iu = bus.issue_valid ? oh_index(bus.issue_unit) : -1;
        wu = bus.wb_valid ? oh_index(bus.wb_unit) : -1;
        $display("txn t=%0t issue=%0b idx=%0d unit=%0d wb=%0b idx=%0d unit=%0d",
                 $time, bus.issue_valid, iidx, iu, bus.wb_valid, widx, wu);
        if (bus.issue_valid && iu < 0) merr = 1;
        if (iu >= 0 && mcnt[iu] == UMAX) merr = 1;
        if (wu >= 0 && mcnt[wu] == 0) merr = 1;
        if (bus.wb_valid && (!mbusy[widx] || mtag[widx] != wu)) merr = 1;
        for (int u = 0; u < UC; u++) begin
            d = (iu == u ? 1 : 0) - (wu == u ? 1 : 0);
            if (d > 0 && mcnt[u] < UMAX) mcnt[u]++;
            if (d < 0 && mcnt[u] > 0) mcnt[u]--;
        end
        if (bus.wb_valid) mbusy[widx] = 0;
        if (bus.issue_valid && iidx != 0) begin mbusy[iidx] = 1; mtag[iidx] = iu; end
        if (bus.issue_valid && iu >= 0) inflight.push_back('{iidx, iu});
        @(negedge clk);
        idle_valids();
    endtask

    // Asynchronous reset in the middle of a cycle.
    task automatic do_reset();
        #2;
        reset = 1;
        model_reset();
        #1;
        check("reset.rd_busy",   bus.rd_busy,   0);
        check("reset.unit_full", bus.unit_full, 0);
        check("reset.unit_idle", bus.unit_idle, 1);
        check("reset.scbd_err",  bus.scbd_err,  0);
        idle_valids();
        @(negedge clk);
        reset = 0;
    endtask

    initial begin
        idle_valids();
        {bus.id_rs1, bus.id_rs2, bus.id_rs3, bus.id_rd} = '0;
        {bus.id_rs1_fp, bus.id_rs2_fp, bus.id_rs3_fp, bus.id_rd_fp} = '0;
        {bus.id_use_rs1, bus.id_use_rs2, bus.id_use_rs3, bus.id_use_rd} = '0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 0;

        // Reset state with ID reading f5.
        bus.id_use_rs1 = 1; bus.id_rs1 = 5; bus.id_rs1_fp = 1;
        settle("rst");
        check("rst_busy", bus.rd_busy, 0);
        check("rst_idle", bus.unit_idle, 1);
        check("rst_full", bus.unit_full, 0);
        advance();

        // f5 to FDIV, then look it up as f5 and as x5.
        issue(5, 1, 6'h04); settle("iss_f5"); advance();
        settle("f5_look"); check("f5_busy", bus.rd_busy, 1);
        bus.id_rs1_fp = 0;
        settle("x5_look"); check("x5_busy", bus.rd_busy, 0);
        advance();

        // Fill FMUL, then overflow it.
        for (int r = 1; r <= 4; r++) begin issue(r, 1, 6'h10); settle("fmul"); advance(); end
        settle("fmul_full"); check("fmul_full", bus.unit_full, 6'h10);
        check("fmul_err0", bus.scbd_err, 0);
        issue(6, 1, 6'h10); settle("fmul5"); advance();
        settle("fmul_over"); check("fmul_over_err", bus.scbd_err, 1);
        check("fmul_still_full", bus.unit_full, 6'h10);
        wb(1, 1, 6'h10); settle("fmul_wb"); advance();
        settle("fmul_cnt3"); check("fmul_cnt3", bus.unit_full, 6'h00);

        // Write-back f5 while ID reads f5.
        bus.id_rs1 = 5; bus.id_rs1_fp = 1;
        wb(5, 1, 6'h04); settle("wb_f5");
`ifdef SCBD_WB_BYPASS_EN
        check("wb_cycle_busy", bus.rd_busy, 0);
`else
        check("wb_cycle_busy", bus.rd_busy, 1);
`endif
        advance();
        settle("after_wb"); check("after_wb_busy", bus.rd_busy, 0);

        // Same-cycle write-back and issue of f2; later stale FADD write-back.
        do_reset();
        issue(2, 1, 6'h20); settle("f2_fadd"); advance();
        issue(9, 1, 6'h20); settle("f9_fadd"); advance();
        wb(2, 1, 6'h20); issue(2, 1, 6'h02); settle("f2_swap"); advance();
        bus.id_rs1 = 2;
        settle("f2_kept"); check("f2_kept", bus.rd_busy, 1);
        check("f2_err0", bus.scbd_err, 0);
        wb(2, 1, 6'h20); settle("f2_stale"); advance();
        settle("f2_tag_err"); check("f2_tag_err", bus.scbd_err, 1);

        // x0 issue via DIV, then reset in flight.
        do_reset();
        issue(0, 0, 6'h02); settle("x0_iss"); advance();
        bus.id_rs1 = 0; bus.id_rs1_fp = 0;
        settle("x0_look"); check("x0_busy", bus.rd_busy, 0);
        check("x0_idle", bus.unit_idle, 0);
        issue(3, 1, 6'h20); settle("f3_iss"); advance();
        bus.id_rs1 = 3; bus.id_rs1_fp = 1;
        settle("f3_look"); check("f3_busy", bus.rd_busy, 1);
        do_reset();
        settle("post_reset");

        // Randomized traffic.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 1) == 1)
                issue($urandom_range(0, 7), 1'($urandom_range(0, 1)), 6'(1 << $urandom_range(0, 5)));
            if (inflight.size() > 0 && $urandom_range(0, 3) != 0) begin
                int k;
                k = $urandom_range(0, inflight.size() - 1);
                wb(inflight[k].idx % 32, 1'(inflight[k].idx / 32), 6'(1 << inflight[k].unit));
                inflight.delete(k);
            end else if ($urandom_range(0, 7) == 0) begin
                wb($urandom_range(0, 7), 1'($urandom_range(0, 1)), 6'(1 << $urandom_range(0, 5)));
            end
            bus.id_use_rs1 = 1'($urandom_range(0, 1)); bus.id_rs1 = 5'($urandom_range(0, 7));
            bus.id_use_rs2 = 1'($urandom_range(0, 1)); bus.id_rs2 = 5'($urandom_range(0, 7));
            bus.id_use_rs3 = 1'($urandom_range(0, 1)); bus.id_rs3 = 5'($urandom_range(0, 7));
            bus.id_use_rd  = 1'($urandom_range(0, 1)); bus.id_rd  = 5'($urandom_range(0, 7));
            bus.id_rs1_fp = 1'($urandom_range(0, 1)); bus.id_rs2_fp = 1'($urandom_range(0, 1));
            bus.id_rs3_fp = 1'($urandom_range(0, 1)); bus.id_rd_fp  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                settle("rnd");
                advance();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
